adc_rr_arbiter: RTL and testbench

Sequencer/arbiter that shares one 8-bit A/D converter (soc/eoc handshake) among three consumers, each served through its own dav_/rfd output handshake on a shared data bus. Grants are round-robin, so no consumer starves. A watchdog aborts a conversion whose eoc never moves. The block sits between the single converter front-end and the three min/filter units that previously each owned a converter.

---
 rtl/adc_rr_arbiter_pkg.sv | 22 ++
 rtl/adc_rr_arbiter_if.sv | 26 ++
 rtl/adc_rr_arbiter_rr_pick3.sv | 27 ++
 rtl/adc_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_adc_rr_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/adc_rr_arbiter_pkg.sv
// Shared types and constants for the A/D converter round-robin arbiter.
// Also used by the 3-channel picker, which is shared with other sequencers.
package adc_arb_pkg;

  localparam int NCONS = 3;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ARB    = 3'd0,
    EOC_LO = 3'd1,
    EOC_HI = 3'd2,
    DAV    = 3'd3,
    RFD_LO = 3'd4,
    RFD_HI = 3'd5
  } arb_state_e;

  // Advance a consumer index modulo 3; an out-of-range index wraps to 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/adc_rr_arbiter_if.sv
// Converter and consumer signals of the arbiter, bundled as one interface.
// The master side is the arbiter; the slave side is the converter plus consumers.
interface adc_rr_arbiter_if;
  import adc_arb_pkg::*;

  logic             soc;
  logic             eoc;
  logic [7:0]       x;
  logic [NCONS-1:0] req;
  logic [7:0]       data;
  logic [NCONS-1:0] dav_;
  logic [NCONS-1:0] rfd;
  logic [1:0]       gnt;
  logic             err;

  modport master (
    output soc, data, dav_, gnt, err,
    input  eoc, x, req, rfd
  );

  modport slave (
    input  soc, data, dav_, gnt, err,
    output eoc, x, req, rfd
  );

endinterface

// File: rtl/adc_rr_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Searches ptr+1, ptr+2, ptr (mod 3) and reports the first active requester.
module rr_pick3
  import adc_arb_pkg::*;
(
  input  logic [NCONS-1:0] i_req,
  input  logic [1:0]       i_ptr,
  output logic             o_any,
  output logic [1:0]       o_w
);

  logic [1:0] w_cand;

  always_comb begin
    o_any  = 1'b0;
    o_w    = 2'd0;
    w_cand = i_ptr;
    for (int k = 0; k < NCONS; k++) begin
      w_cand = next_idx(w_cand);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_w   = w_cand;
      end
    end
  end

endmodule

// File: rtl/adc_rr_arbiter.sv
// Shares one soc/eoc A/D converter among three dav_/rfd consumers, granted
// round-robin, with a per-phase eoc watchdog that aborts a stuck conversion.
module adc_rr_arbiter
  import adc_arb_pkg::*;
#(
  parameter int TMO = 255
) (
  input  logic              clock,
  input  logic              reset_,
  adc_rr_arbiter_if.master  bus
);

  arb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [1:0]       r_gnt, w_gnt_nxt;
  logic             r_soc, w_soc_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic [NCONS-1:0] r_dav_, w_dav_nxt;
  logic             r_err, w_err_nxt;

  logic             w_any;
  logic [1:0]       w_win;
  logic             w_tmo;

  rr_pick3 u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_w   (w_win)
  );

  // The counter is cleared on entry to each eoc phase, so TMO-1 marks the TMO-th edge there.
  assign w_tmo = (r_cnt == CNT_W'(TMO - 1));

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= ARB;
      r_cnt   <= '0;
      r_ptr   <= 2'd2;
      r_gnt   <= 2'd0;
      r_soc   <= 1'b0;
      r_data  <= 8'h00;
      r_dav_  <= '1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_soc   <= w_soc_nxt;
      r_data  <= w_data_nxt;
      r_dav_  <= w_dav_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_soc_nxt   = r_soc;
    w_data_nxt  = r_data;
    w_dav_nxt   = r_dav_;
    w_err_nxt   = r_err;
    unique case (r_state)
      ARB: begin
        if (w_any) begin
          w_gnt_nxt   = w_win;
          w_soc_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = EOC_LO;
        end
      end
      EOC_LO: begin
        if (!bus.eoc) begin
          w_soc_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = EOC_HI;
        end else if (w_tmo) begin
          w_soc_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_ptr_nxt   = r_gnt;
          w_state_nxt = ARB;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      EOC_HI: begin
        if (bus.eoc) begin
          w_data_nxt  = bus.x;
          w_state_nxt = DAV;
        end else if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_ptr_nxt   = r_gnt;
          w_state_nxt = ARB;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DAV: begin
        w_dav_nxt[r_gnt] = 1'b0;
        w_state_nxt      = RFD_LO;
      end
      RFD_LO: begin
        if (!bus.rfd[r_gnt]) begin
          w_dav_nxt[r_gnt] = 1'b1;
          w_state_nxt      = RFD_HI;
        end
      end
      RFD_HI: begin
        if (bus.rfd[r_gnt]) begin
          w_ptr_nxt   = r_gnt;
          w_state_nxt = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  assign bus.soc  = r_soc;
  assign bus.data = r_data;
  assign bus.dav_ = r_dav_;
  assign bus.gnt  = r_gnt;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_adc_rr_arbiter.sv
// Self-checking bench for adc_rr_arbiter: directed scenarios, then a long
// randomized run against a transaction-level model of pending requests.
module tb_adc_rr_arbiter;

  localparam int TMO = 8;

  logic clock;
  logic reset_;

  adc_rr_arbiter_if bus ();

  adc_rr_arbiter #(.TMO(TMO)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checkCount = 0;
  int passCount  = 0;

  logic [2:0] pending;
  int         mPtr;
  logic       mErr;
  logic [7:0] mData;
  int         curW;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
  endtask

  // Round-robin reference: first requester in order ptr+1, ptr+2, ptr.
  function automatic int pickRef(input logic [2:0] r, input int p);
    for (int k = 1; k <= 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  // Advance one cycle; optionally scramble inputs the DUT must ignore.
  task automatic applyStimulus(input bit noise);
    logic [2:0] keep;
    if (noise) begin
      keep    = (curW < 3) ? (3'b001 << curW) : 3'b000;
      bus.req = 3'($urandom_range(0, 7));
      bus.rfd = (3'($urandom_range(0, 7)) & ~keep) | (bus.rfd & keep);
    end
    @(negedge clock);
  endtask

  task automatic doReset();
    reset_ = 1'b0;
    #1;
    checkOutput("rstSoc", 32'(bus.soc), 32'(0));
    checkOutput("rstDav", 32'(bus.dav_), 32'(3'b111));
    checkOutput("rstGnt", 32'(bus.gnt), 32'(0));
    checkOutput("rstErr", 32'(bus.err), 32'(0));
    checkOutput("rstData", 32'(bus.data), 32'(0));
    mPtr = 2; mErr = 1'b0; mData = 8'h00; curW = 3;
    bus.eoc = 1'b1; bus.rfd = 3'b111; bus.req = 3'b000;
    @(negedge clock);
    reset_ = 1'b1;
    applyStimulus(0);
    checkOutput("idleAfterRst", 32'(bus.soc), 32'(0));
  endtask

  // One service from ARB; rstPhase 1 resets during EOC_HI, 2 during RFD_LO.
  task automatic serveOne(input logic [7:0] xVal, input int d1, input int d2,
                          input int h1, input int h2, input int rstPhase);
    int w;
    logic [2:0] expLow;
    w = pickRef(pending, mPtr);
    bus.req = pending;
    bus.eoc = 1'b1;
    bus.rfd[w] = 1'b1;
    applyStimulus(0);
    checkOutput("socRise", 32'(bus.soc), 32'(1));
    checkOutput("gnt", 32'(bus.gnt), 32'(w));
    checkOutput("davIdle", 32'(bus.dav_), 32'(3'b111));
    curW = w;
    if (d1 >= TMO) begin
      repeat (TMO - 1) applyStimulus(1);
      checkOutput("socHeld", 32'(bus.soc), 32'(1));
      applyStimulus(1);
      checkOutput("abortSoc", 32'(bus.soc), 32'(0));
      checkOutput("abortErr", 32'(bus.err), 32'(1));
      checkOutput("abortDav", 32'(bus.dav_), 32'(3'b111));
      mErr = 1'b1; mPtr = w;
      return;
    end
    repeat (d1) applyStimulus(1);
    bus.eoc = 1'b0;
    applyStimulus(1);
    checkOutput("socFall", 32'(bus.soc), 32'(0));
    if (rstPhase == 1) begin doReset(); return; end
    if (d2 >= TMO) begin
      repeat (TMO) applyStimulus(1);
      checkOutput("hiAbortDav", 32'(bus.dav_), 32'(3'b111));
      checkOutput("hiAbortErr", 32'(bus.err), 32'(1));
      checkOutput("hiAbortData", 32'(bus.data), 32'(mData));
      mErr = 1'b1; mPtr = w;
      bus.eoc = 1'b1;
      return;
    end
    repeat (d2) applyStimulus(1);
    bus.x = xVal;
    bus.eoc = 1'b1;
    applyStimulus(1);
    mData = xVal;
    checkOutput("data", 32'(bus.data), 32'(mData));
    checkOutput("davNotYet", 32'(bus.dav_), 32'(3'b111));
    applyStimulus(1);
    expLow = 3'b111;
    expLow[w] = 1'b0;
    checkOutput("davLow", 32'(bus.dav_), 32'(expLow));
    pending[w] = 1'b0;
    repeat (h1) begin
      applyStimulus(1);
      checkOutput("davHold", 32'(bus.dav_), 32'(expLow));
      checkOutput("socIdle", 32'(bus.soc), 32'(0));
    end
    if (rstPhase == 2) begin doReset(); return; end
    bus.rfd[w] = 1'b0;
    applyStimulus(1);
    checkOutput("davRelease", 32'(bus.dav_), 32'(3'b111));
    checkOutput("dataHeld", 32'(bus.data), 32'(mData));
    repeat (h2) applyStimulus(1);
    bus.rfd[w] = 1'b1;
    applyStimulus(1);
    mPtr = w;
    checkOutput("errSticky", 32'(bus.err), 32'(mErr));
  endtask

  initial begin
    reset_ = 1'b0;
    bus.eoc = 1'b1; bus.x = 8'h00; bus.req = 3'b000; bus.rfd = 3'b111;
    pending = 3'b000; mPtr = 2; mErr = 1'b0; mData = 8'h00; curW = 3;
    @(negedge clock);
    doReset();

    $display("[TB] all requesting, ideal partners");
    pending = 3'b111; serveOne(8'h11, 0, 0, 0, 0, 0);
    pending |= 3'b111; serveOne(8'h22, 0, 0, 0, 0, 0);
    pending |= 3'b111; serveOne(8'h33, 0, 0, 0, 0, 0);
    pending |= 3'b111; serveOne(8'h44, 0, 0, 0, 0, 0);

    $display("[TB] single requester then re-request");
    pending = 3'b000;
    doReset();
    pending = 3'b100; serveOne(8'h5A, 1, 1, 1, 1, 0);
    pending |= 3'b101; serveOne(8'h6B, 0, 2, 0, 0, 0);
    serveOne(8'h7C, 2, 0, 1, 0, 0);

    $display("[TB] stuck eoc watchdog");
    pending = 3'b010; serveOne(8'h00, 100, 0, 0, 0, 0);
    pending |= 3'b001; serveOne(8'h81, 0, 0, 0, 0, 0);
    serveOne(8'h92, 0, 0, 0, 0, 0);

    $display("[TB] slow consumer");
    pending = 3'b010; serveOne(8'hA3, 0, 0, 20, 0, 0);
    pending |= 3'b101; serveOne(8'hB4, 0, 0, 0, 0, 0);
    serveOne(8'hC5, 0, 0, 0, 0, 0);

    $display("[TB] reset mid conversion and mid handshake");
    pending = 3'b111; serveOne(8'hD6, 0, 0, 0, 0, 1);
    pending |= 3'b111; serveOne(8'hE7, 0, 0, 2, 0, 2);
    serveOne(8'hF8, 0, 0, 0, 0, 0);

    $display("[TB] random run");
    for (int n = 0; n < 1000; n++) begin
      int d1, d2;
      if ($urandom_range(0, 1) == 1) pending |= 3'($urandom_range(0, 7));
      if (pending == 3'b000) begin
        bus.req = 3'b000;
        applyStimulus(0);
        checkOutput("idleSoc", 32'(bus.soc), 32'(0));
        pending = 3'($urandom_range(1, 7));
      end
      d1 = ($urandom_range(0, 24) == 0) ? TMO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      d2 = ($urandom_range(0, 24) == 0) ? TMO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      serveOne(8'($urandom_range(0, 255)), d1, d2,
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
